// File: rtl/time_keeper_if.sv
// Signal bundle between the time_keeper core and its environment.
// The environment drives the clk_1hz wave and set/alarm controls; the core returns the time, pulses and alarm state.
interface time_keeper_if;
  logic       clk_1hz;
  logic       set_time;
  logic       set_alarm;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic       alarm_en;
  logic       alarm_stop;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;
  logic       sec_tick;
  logic       set_err;
  logic       alarm_ring;
  logic       alarm_state;  // debug view of the alarm FSM: 0 = IDLE, 1 = RINGING

  modport master (
    output clk_1hz, set_time, set_alarm, set_hh, set_mm, alarm_en, alarm_stop,
    input  hh, mm, ss, sec_tick, set_err, alarm_ring, alarm_state
  );

  modport slave (
    input  clk_1hz, set_time, set_alarm, set_hh, set_mm, alarm_en, alarm_stop,
    output hh, mm, ss, sec_tick, set_err, alarm_ring, alarm_state
  );
endinterface

// File: rtl/time_keeper.sv
// 24 h hh:mm:ss time-of-day counter advanced by rising edges of an asynchronous 1 Hz wave,
// with one alarm time and a ringing FSM that auto-silences after RING_SECS seconds.
module time_keeper #(
  parameter int SYNC_STAGES = 2,
  parameter int RING_SECS   = 60
) (
  input  logic          clk,
  input  logic          rst_n,
  time_keeper_if.slave  bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    RINGING = 1'b1
  } alarm_state_t;

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick;

  logic [4:0]   hh_q;
  logic [5:0]   mm_q;
  logic [5:0]   ss_q;
  logic [4:0]   alarm_hh;
  logic [5:0]   alarm_mm;
  logic         sec_tick_q;
  logic         set_err_q;
  logic         ring_q;
  logic [7:0]   ring_cnt;
  alarm_state_t state;

  logic [4:0] nx_hh;
  logic [5:0] nx_mm;
  logic [5:0] nx_ss;
  logic       set_ok;
  logic       load_time;
  logic       load_alarm;
  logic       advance;
  logic       alarm_hit;

  // clk_1hz is asynchronous data: synchronise, then detect rising edges only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.clk_1hz};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_comb begin
    nx_hh = hh_q;
    nx_mm = mm_q;
    nx_ss = ss_q + 6'd1;
    if (ss_q >= 6'd59) begin
      nx_ss = '0;
      if (mm_q >= 6'd59) begin
        nx_mm = '0;
        nx_hh = (hh_q >= 5'd23) ? 5'd0 : hh_q + 5'd1;
      end else begin
        nx_mm = mm_q + 6'd1;
      end
    end
  end

  assign set_ok     = (bus.set_hh <= 5'd23) && (bus.set_mm <= 6'd59);
  assign load_time  = bus.set_time & set_ok;
  assign load_alarm = bus.set_alarm & set_ok;
  // A successful time load swallows a coincident tick.
  assign advance    = tick & ~load_time;
  assign alarm_hit  = advance && (nx_ss == 6'd0) && (nx_hh == alarm_hh) &&
                      (nx_mm == alarm_mm) && bus.alarm_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      alarm_hh   <= '0;
      alarm_mm   <= '0;
      sec_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      sec_tick_q <= advance;
      set_err_q  <= (bus.set_time | bus.set_alarm) & ~set_ok;
      if (load_time) begin
        hh_q <= bus.set_hh;
        mm_q <= bus.set_mm;
        ss_q <= '0;
      end else if (advance) begin
        hh_q <= nx_hh;
        mm_q <= nx_mm;
        ss_q <= nx_ss;
      end
      if (load_alarm) begin
        alarm_hh <= bus.set_hh;
        alarm_mm <= bus.set_mm;
      end
    end
  end

  // Ring counter counts ticks after entry; leaving on RING_LAST gives RING_SECS ticks of ringing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ring_q   <= 1'b0;
      ring_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (alarm_hit && !bus.alarm_stop) begin
            state    <= RINGING;
            ring_q   <= 1'b1;
            ring_cnt <= '0;
          end
        end
        RINGING: begin
          if (bus.alarm_stop || !bus.alarm_en) begin
            state  <= IDLE;
            ring_q <= 1'b0;
          end else if (advance) begin
            if (ring_cnt == RING_LAST) begin
              state  <= IDLE;
              ring_q <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          ring_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hh          = hh_q;
  assign bus.mm          = mm_q;
  assign bus.ss          = ss_q;
  assign bus.sec_tick    = sec_tick_q;
  assign bus.set_err     = set_err_q;
  assign bus.alarm_ring  = ring_q;
  assign bus.alarm_state = state;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: counting, carries, set validation, alarm ring/stop/timeout, async reset.
module tb_time_keeper;

  logic clk;
  logic rst_n;
  time_keeper_if bus ();

  time_keeper #(.SYNC_STAGES(2), .RING_SECS(60)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks  = 0;
  int n_err     = 0;
  int tick_cnt  = 0;
  int range_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observers sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (bus.sec_tick === 1'b1) tick_cnt++;
    if (rst_n === 1'b1 && (bus.hh > 5'd23 || bus.mm > 6'd59 || bus.ss > 6'd59)) range_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    bus.clk_1hz = 1'b1;
    repeat (4) step();
    bus.clk_1hz = 1'b0;
    repeat (4) step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_set(input logic t, input logic a, input int h, input int m);
    bus.set_hh    = 5'(h);
    bus.set_mm    = 6'(m);
    bus.set_time  = t;
    bus.set_alarm = a;
    step();
    bus.set_time  = 1'b0;
    bus.set_alarm = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hh"}, 32'(bus.hh), 32'(h));
    chk({tag, "_mm"}, 32'(bus.mm), 32'(m));
    chk({tag, "_ss"}, 32'(bus.ss), 32'(s));
  endtask

  initial begin
    int tc0;
    rst_n          = 1'b0;
    bus.clk_1hz    = 1'b0;
    bus.set_time   = 1'b0;
    bus.set_alarm  = 1'b0;
    bus.set_hh     = '0;
    bus.set_mm     = '0;
    bus.alarm_en   = 1'b0;
    bus.alarm_stop = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_time("reset", 0, 0, 0);
    chk("reset_sec_tick", 32'(bus.sec_tick), 0);
    chk("reset_set_err", 32'(bus.set_err), 0);
    chk("reset_ring", 32'(bus.alarm_ring), 0);
    chk("reset_state", 32'(bus.alarm_state), 0);
    rst_n = 1'b1;
    step();

    // 1: three ticks with SYNC_STAGES+1 latency
    for (int i = 0; i < 3; i++) begin
      bus.clk_1hz = 1'b1;
      step();
      chk("lat_e1", 32'(bus.sec_tick), 0);
      step();
      chk("lat_e2", 32'(bus.sec_tick), 0);
      step();
      chk("lat_e3_tick", 32'(bus.sec_tick), 1);
      chk("lat_e3_ss", 32'(bus.ss), 32'(i + 1));
      step();
      chk("tick_width", 32'(bus.sec_tick), 0);
      bus.clk_1hz = 1'b0;
      repeat (4) step();
    end
    chk("three_ss", 32'(bus.ss), 3);
    chk("three_pulses", 32'(tick_cnt), 3);

    // 2: roll over from 23:59:00
    do_set(1'b1, 1'b0, 23, 59);
    chk_time("set_2359", 23, 59, 0);
    for (int i = 1; i <= 59; i++) begin
      do_tick();
      chk("roll_ss", 32'(bus.ss), 32'(i));
    end
    chk_time("pre_roll", 23, 59, 59);
    do_tick();
    chk_time("rollover", 0, 0, 0);
    chk("no_ring_disabled", 32'(bus.alarm_ring), 0);

    // 3: rejected set_time
    do_set(1'b1, 1'b0, 24, 0);
    chk("err_hh24", 32'(bus.set_err), 1);
    chk_time("err_hh24", 0, 0, 0);
    step();
    chk("err_width", 32'(bus.set_err), 0);
    do_set(1'b1, 1'b0, 10, 60);
    chk("err_mm60", 32'(bus.set_err), 1);
    chk_time("err_mm60", 0, 0, 0);
    do_set(1'b1, 1'b0, 5, 5);
    chk("ok_no_err", 32'(bus.set_err), 0);
    chk_time("ok_set", 5, 5, 0);

    // 4: alarm 07:30 rings for 60 ticks; a rejected set_alarm must not disturb it
    do_set(1'b0, 1'b1, 7, 30);
    chk("alarm_ok", 32'(bus.set_err), 0);
    do_set(1'b0, 1'b1, 24, 30);
    chk("alarm_err", 32'(bus.set_err), 1);
    chk_time("alarm_err_time", 5, 5, 0);
    bus.alarm_en = 1'b1;
    do_set(1'b1, 1'b0, 7, 29);
    ticks(58);
    chk_time("at_072958", 7, 29, 58);
    do_tick();
    chk("ring_before", 32'(bus.alarm_ring), 0);
    bus.clk_1hz = 1'b1;
    step();
    step();
    chk("ring_not_early", 32'(bus.alarm_ring), 0);
    step();
    chk("ring_rise", 32'(bus.alarm_ring), 1);
    chk_time("ring_rise", 7, 30, 0);
    chk("ring_state", 32'(bus.alarm_state), 1);
    step();
    bus.clk_1hz = 1'b0;
    repeat (4) step();
    ticks(59);
    chk("ring_59", 32'(bus.alarm_ring), 1);
    do_tick();
    chk("ring_timeout", 32'(bus.alarm_ring), 0);
    chk_time("timeout_time", 7, 31, 0);

    do_set(1'b1, 1'b0, 7, 29);
    ticks(60);
    chk("ring2_rise", 32'(bus.alarm_ring), 1);
    ticks(5);
    chk_time("at_073005", 7, 30, 5);
    chk("ring2_held", 32'(bus.alarm_ring), 1);
    bus.alarm_stop = 1'b1;
    step();
    bus.alarm_stop = 1'b0;
    chk("stop_ring", 32'(bus.alarm_ring), 0);
    chk("stop_state", 32'(bus.alarm_state), 0);

    // 5a: set_time coincident with a tick
    tc0 = tick_cnt;
    bus.clk_1hz = 1'b1;
    step();
    step();
    bus.set_hh   = 5'd12;
    bus.set_mm   = 6'd34;
    bus.set_time = 1'b1;
    step();
    bus.set_time = 1'b0;
    chk_time("set_vs_tick", 12, 34, 0);
    chk("set_vs_tick_pulse", 32'(bus.sec_tick), 0);
    step();
    bus.clk_1hz = 1'b0;
    repeat (4) step();
    chk("set_vs_tick_cnt", 32'(tick_cnt - tc0), 0);
    chk_time("set_vs_tick_after", 12, 34, 0);

    // 5a': set_time landing on the alarm time does not trigger
    do_set(1'b1, 1'b0, 7, 30);
    chk("set_on_alarm", 32'(bus.alarm_ring), 0);

    // 5b: trigger coincident with alarm_stop
    do_set(1'b1, 1'b0, 7, 29);
    ticks(59);
    bus.clk_1hz = 1'b1;
    step();
    step();
    bus.alarm_stop = 1'b1;
    step();
    bus.alarm_stop = 1'b0;
    chk_time("stop_vs_trig", 7, 30, 0);
    chk("stop_vs_trig_ring", 32'(bus.alarm_ring), 0);
    step();
    bus.clk_1hz = 1'b0;
    repeat (4) step();
    ticks(2);
    chk("stop_vs_trig_later", 32'(bus.alarm_ring), 0);

    // 5c: alarm disabled at match
    bus.alarm_en = 1'b0;
    do_set(1'b1, 1'b0, 7, 29);
    ticks(60);
    chk_time("disabled_match", 7, 30, 0);
    chk("disabled_ring", 32'(bus.alarm_ring), 0);

    // 6: async reset mid-ring
    bus.alarm_en = 1'b1;
    do_set(1'b1, 1'b0, 7, 29);
    ticks(60);
    chk("pre_reset_ring", 32'(bus.alarm_ring), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_ring", 32'(bus.alarm_ring), 0);
    chk("async_state", 32'(bus.alarm_state), 0);
    chk_time("async", 0, 0, 0);
    chk("async_tick", 32'(bus.sec_tick), 0);
    step();
    rst_n = 1'b1;
    step();
    do_tick();
    chk_time("resume", 0, 0, 1);
    chk("resume_ring", 32'(bus.alarm_ring), 0);

    chk("range_guard", 32'(range_bad), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
